// File: rtl/step_rate_sequencer.sv
// Stepper-motor phase sequencer with a programmable step-rate prescaler.
// Define STEP_RATE_SEQUENCER_HALF_STEP_EN for 8-state half-step drive.
module step_rate_sequencer #(
  parameter int POS_W = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

`ifdef STEP_RATE_SEQUENCER_HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic [3:0] rate;

  assign clk  = io_in[0];
  assign rst  = io_in[1];
  assign en   = io_in[2];
  assign dir  = io_in[3];
  assign rate = io_in[7:4];

  logic [3:0]      cnt_q, cnt_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [3:0]      coil_q, coil_d;
  logic            step_q, dir_q, run_q, wrap_q;
  logic            dir_d, wrap_d;
  logic            step;

  assign step = en & (cnt_q == 4'd0);

  // Prescaler: hold reload value while idle, count down while enabled.
  always_comb begin
    cnt_d = rate;
    if (en && cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  // Phase/position advance on a step, with wrap detection.
  always_comb begin
    ph_d   = ph_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (step) begin
      dir_d = dir;
      if (dir) begin
        ph_d   = ph_q - PH_W'(1);
        pos_d  = pos_q - POS_W'(1);
        wrap_d = (pos_q == '0);
      end else begin
        ph_d   = ph_q + PH_W'(1);
        pos_d  = pos_q + POS_W'(1);
        wrap_d = &pos_q;
      end
    end
  end

  // Coil pattern for the next phase, active-low.
  always_comb begin
    coil_d = 4'b1110;
`ifdef STEP_RATE_SEQUENCER_HALF_STEP_EN
    case (ph_d)
      3'd0:    coil_d = 4'b1110;
      3'd1:    coil_d = 4'b1100;
      3'd2:    coil_d = 4'b1101;
      3'd3:    coil_d = 4'b1001;
      3'd4:    coil_d = 4'b1011;
      3'd5:    coil_d = 4'b0011;
      3'd6:    coil_d = 4'b0111;
      default: coil_d = 4'b0110;
    endcase
`else
    case (ph_d)
      2'd0:    coil_d = 4'b1110;
      2'd1:    coil_d = 4'b1101;
      2'd2:    coil_d = 4'b1011;
      default: coil_d = 4'b0111;
    endcase
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 4'd0;
      ph_q   <= '0;
      pos_q  <= '0;
      coil_q <= 4'b1110;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
      run_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ph_q   <= ph_d;
      pos_q  <= pos_d;
      coil_q <= coil_d;
      step_q <= step;
      dir_q  <= dir_d;
      run_q  <= en;
      wrap_q <= wrap_d;
    end
  end

  assign io_out = {wrap_q, run_q, dir_q, step_q, coil_q};

endmodule

// File: tb/tb_step_rate_sequencer.sv
// Directed bench for step_rate_sequencer with a per-cycle reference model.
// Honors STEP_RATE_SEQUENCER_HALF_STEP_EN to pick the phase table.
module tb_step_rate_sequencer;

`ifdef STEP_RATE_SEQUENCER_HALF_STEP_EN
  localparam int NPH = 8;
  logic [3:0] enc [NPH] = '{4'b1110, 4'b1100, 4'b1101, 4'b1001,
                            4'b1011, 4'b0011, 4'b0111, 4'b0110};
  localparam logic [3:0] F1 = 4'b1100;
  localparam logic [3:0] F2 = 4'b1101;
  localparam logic [3:0] R1 = 4'b0110;
`else
  localparam int NPH = 4;
  logic [3:0] enc [NPH] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [3:0] F1 = 4'b1101;
  localparam logic [3:0] F2 = 4'b1011;
  localparam logic [3:0] R1 = 4'b0111;
`endif
  localparam int POSN = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] rate = 4'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {rate, dir, en, rst, clk};

  step_rate_sequencer #(.POS_W(8)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_cnt, m_ph, m_pos;
  bit m_step, m_dir, m_run, m_wrap;

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ph = 0; m_pos = 0;
    m_step = 0; m_dir = 0; m_run = 0; m_wrap = 0;
  endtask

  task automatic model_edge();
    bit stp;
    int d, np;
    stp = 0;
    if (!en) m_cnt = rate;
    else if (m_cnt == 0) begin
      stp = 1;
      m_cnt = rate;
    end else m_cnt = m_cnt - 1;
    m_step = stp;
    m_run = en;
    m_wrap = 0;
    if (stp) begin
      d = dir ? -1 : 1;
      m_dir = dir;
      np = m_pos + d;
      m_wrap = (np < 0) || (np >= POSN);
      m_pos = (np + POSN) % POSN;
      m_ph = (m_ph + d + NPH) % NPH;
    end
  endtask

  function automatic logic [7:0] model_out();
    return {m_wrap, m_run, m_dir, m_step, enc[m_ph]};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("cycle", io_out, model_out());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("async_reset", io_out, 8'h0E);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", io_out, 8'h0E);
    rst = 1'b0;
  endtask

  initial begin
    #2;
    rate = 4'd9; dir = 1'b1; en = 1'b1;
    do_reset();

    // forward, R=3
    rst = 1'b1; #1;
    en = 1'b1; dir = 1'b0; rate = 4'd3;
    do_reset();
    tick(1);
    check("fwd_first_step", {7'd0, io_out[4]}, 8'd1);
    check("fwd_first_phase", {4'd0, io_out[3:0]}, {4'd0, F1});
    check("fwd_running", {7'd0, io_out[6]}, 8'd1);
    tick(3);
    check("fwd_gap", {7'd0, io_out[4]}, 8'd0);
    tick(1);
    check("fwd_second_step", {7'd0, io_out[4]}, 8'd1);
    check("fwd_second_phase", {4'd0, io_out[3:0]}, {4'd0, F2});
    tick(12);
    dir = 1'b1; rate = 4'd1;
    tick(10);

    // reverse, R=0
    rate = 4'd0; dir = 1'b1; en = 1'b1;
    do_reset();
    tick(1);
    check("rev_phase", {4'd0, io_out[3:0]}, {4'd0, R1});
    check("rev_wrap", {7'd0, io_out[7]}, 8'd1);
    check("rev_dir", {7'd0, io_out[5]}, 8'd1);
    tick(1);
    check("rev_wrap_clear", {7'd0, io_out[7]}, 8'd0);
    check("rev_step_cont", {7'd0, io_out[4]}, 8'd1);
    tick(6);

    // forward wrap on the 256th step
    rate = 4'd0; dir = 1'b0; en = 1'b1;
    do_reset();
    tick(255);
    check("wrap_not_early", {7'd0, io_out[7]}, 8'd0);
    tick(1);
    check("wrap_256", {6'd0, io_out[7], io_out[4]}, 8'd3);

    // enable drop when cnt hits zero
    rate = 4'd5; dir = 1'b0; en = 1'b1;
    do_reset();
    tick(6);
    en = 1'b0;
    tick(1);
    check("drop_no_step", {7'd0, io_out[4]}, 8'd0);
    check("drop_run_low", {7'd0, io_out[6]}, 8'd0);
    check("drop_phase_held", {4'd0, io_out[3:0]}, {4'd0, F1});
    en = 1'b1;
    tick(5);
    check("reen_wait", {7'd0, io_out[4]}, 8'd0);
    tick(1);
    check("reen_step", {7'd0, io_out[4]}, 8'd1);
    check("reen_phase", {4'd0, io_out[3:0]}, {4'd0, F2});

    // mid-pulse reset, then scrambled inputs
    rate = 4'd0; dir = 1'b0; en = 1'b1;
    do_reset();
    tick(3);
    rate = 4'($urandom_range(15)); dir = 1'($urandom_range(1));
    do_reset();
    for (int i = 0; i < 60; i++) begin
      en = ($urandom_range(7) != 0);
      dir = 1'($urandom_range(1));
      rate = 4'($urandom_range(3));
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/step_rate_sequencer.md
STEP_RATE_SEQUENCER -- requirements
Module: step_rate_sequencer

Interface
REQ-001 The block SHALL have one parameter: POS_W, default 8, width of the internal step-position counter.
REQ-002 io_in[0]  input  1  clock; rising edge.
REQ-003 io_in[1]  input  1  reset; asynchronous, active-high.
REQ-004 io_in[2]  input  1  enable; a high value allows stepping.
REQ-005 io_in[3]  input  1  dir; 0 = forward (increment), 1 = reverse (decrement).
REQ-006 io_in[7:4]  input  4  rate R; the step period is R+1 clocks.
REQ-007 io_out[3:0]  output  4  coil phase outputs, active-low.
REQ-008 io_out[4]  output  1  step pulse, one clock wide.
REQ-009 io_out[5]  output  1  direction used by the most recent step.
REQ-010 io_out[6]  output  1  running; enable registered.
REQ-011 io_out[7]  output  1  position wrap pulse, one clock wide.

Function
REQ-012 All outputs SHALL be registered; no combinational input-to-output path.
REQ-013 Prescaler: the block SHALL contain a 4-bit counter cnt.
REQ-014 With enable low, cnt SHALL load R on every edge, and no step occurs.
REQ-015 With enable high and cnt != 0, cnt SHALL decrement, and no step occurs.
REQ-016 With enable high and cnt == 0, a step SHALL occur and cnt SHALL load R.
REQ-017 A change to R SHALL take effect only at the next reload.
REQ-018 R = 0 SHALL produce one step per clock.
REQ-019 On a step edge, the phase state SHALL advance by +1 when dir = 0 and by -1 when dir = 1, modulo the number of states.
REQ-020 On a step edge, dir SHALL be sampled and registered to io_out[5].
REQ-021 In full-step mode, the phase state SHALL be 2 bits.
REQ-022 Full-step encoding of io_out[3:0]: state 0 = 1110, state 1 = 1101, state 2 = 1011, state 3 = 0111.
REQ-023 io_out[4] SHALL be high for exactly the cycle following each step edge, and low otherwise.
REQ-024 The position counter (POS_W bits) SHALL increment on forward steps and decrement on reverse steps, wrapping modulo 2^POS_W.
REQ-025 io_out[7] SHALL pulse high for one cycle, coincident with io_out[4], on a forward step from all-ones to 0 or a reverse step from 0 to all-ones.
REQ-026 io_out[6] SHALL equal enable delayed by one clock.
REQ-027 Enable falling at the same edge where cnt == 0 SHALL produce no step.
REQ-028 A dir change between steps SHALL have no effect until the next step edge; reversal from state s yields s-1 with no skipped or repeated state.
REQ-029 Back-to-back steps (R = 0) SHALL keep io_out[4] high continuously.

Reset
REQ-030 Reset assertion SHALL asynchronously clear the following: phase state = 0 (io_out[3:0] = 1110), cnt = 0, position = 0, io_out[4] = 0, io_out[5] = 0, io_out[6] = 0, io_out[7] = 0.
REQ-031 Reset asserted mid-count or mid-pulse SHALL abort immediately; no step SHALL be issued while reset is high.
REQ-032 Because cnt resets to 0, the first enabled edge after reset release SHALL produce a step.

Configuration
REQ-033 Macro STEP_RATE_SEQUENCER_HALF_STEP_EN selects the phase mode.
REQ-034 With STEP_RATE_SEQUENCER_HALF_STEP_EN defined, the phase state SHALL be 3 bits (8 states).
REQ-035 In half-step mode, even states SHALL drive a single coil and odd states two adjacent coils. Encoding: 0 = 1110, 1 = 1100, 2 = 1101, 3 = 1001, 4 = 1011, 5 = 0011, 6 = 0111, 7 = 0110.
REQ-036 In half-step mode, position SHALL count each half step.
REQ-037 With STEP_RATE_SEQUENCER_HALF_STEP_EN undefined, full-step mode per REQ-021/REQ-022 SHALL apply and no half-step logic SHALL be present.

Verification
REQ-038 Reset check: assert reset with arbitrary inputs -> io_out = 8'h0E immediately, without a clock edge.
REQ-039 Forward stepping: R = 3, dir = 0, enable = 1 after reset -> step at the first edge, then every 4 edges; io_out[3:0] sequence 1101, 1011, 0111, 1110; io_out[4] one cycle high per step.
REQ-040 Reverse stepping: R = 0, dir = 1 from reset -> io_out[3:0] = 0111, 1011, 1101, 1110 on consecutive cycles; io_out[7] pulses on the first step (position 0 -> 255); io_out[5] = 1.
REQ-041 Position wrap: R = 0, dir = 0, POS_W = 8 -> io_out[7] high only on the 256th step, coincident with io_out[4].
REQ-042 Enable drop: R = 5, enable falls when cnt == 0 -> no step, phase held, io_out[6] low one cycle later; on re-enable, the first step occurs R+1 clocks later.
REQ-043 Half-step mode: macro defined, R = 0, dir = 0 -> io_out[3:0] = 1100, 1101, 1001, 1011, 0011, 0111, 0110, 1110; a mid-sequence reset returns to 1110.
